// File: rtl/reg_file_rename.sv
// Architectural register file with ROB producer tags: renames destinations at issue,
// writes values and releases tags at commit, and drops every tag on a misprediction clear.
module reg_file_rename #(
    parameter int ROB_INDEX_BIT = 4,
    parameter int REG_NUM       = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     issue_req,
    input  logic [4:0]               issue_rs1,
    input  logic [4:0]               issue_rs2,
    input  logic [4:0]               issue_rd,
    input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    input  logic [4:0]               commit_rd,
    input  logic [31:0]              commit_val,
    input  logic [ROB_INDEX_BIT-1:0] commit_rob_id,
    output logic [31:0]              rs1_val,
    output logic                     rs1_busy,
    output logic [ROB_INDEX_BIT-1:0] rs1_rob_id,
    output logic [31:0]              rs2_val,
    output logic                     rs2_busy,
    output logic [ROB_INDEX_BIT-1:0] rs2_rob_id,
    output logic [5:0]               busy_count
);

    logic [31:0]              val_q  [REG_NUM];
    logic [ROB_INDEX_BIT-1:0] tag_q  [REG_NUM];
    logic [REG_NUM-1:0]       busy_q;
    logic [5:0]               busy_count_q;

    logic [REG_NUM-1:0]       busy_next;
    logic [5:0]               busy_count_next;
    logic                     commit_release;
    logic                     rename_en;

    // A commit only frees the register when it is still the youngest producer.
    assign commit_release = (commit_rd != 5'd0) && busy_q[commit_rd] &&
                            (tag_q[commit_rd] == commit_rob_id);
    assign rename_en      = issue_req && (issue_rd != 5'd0) && !clear_in;

    always_comb begin
        rs1_val    = val_q[issue_rs1];
        rs1_busy   = busy_q[issue_rs1];
        rs1_rob_id = tag_q[issue_rs1];
        if (issue_rs1 == 5'd0) begin
            rs1_val  = 32'd0;
            rs1_busy = 1'b0;
        end else if (commit_release && (commit_rd == issue_rs1)) begin
            rs1_val  = commit_val;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_val    = val_q[issue_rs2];
        rs2_busy   = busy_q[issue_rs2];
        rs2_rob_id = tag_q[issue_rs2];
        if (issue_rs2 == 5'd0) begin
            rs2_val  = 32'd0;
            rs2_busy = 1'b0;
        end else if (commit_release && (commit_rd == issue_rs2)) begin
            rs2_val  = commit_val;
            rs2_busy = 1'b0;
        end
    end

    // Priority: clear beats everything, rename beats a same-cycle release.
    always_comb begin
        busy_next = busy_q;
        if (commit_release) begin
            busy_next[commit_rd] = 1'b0;
        end
        if (clear_in) begin
            busy_next = '0;
        end else if (rename_en) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
        busy_count_next = 6'd0;
        for (int i = 0; i < REG_NUM; i++) begin
            busy_count_next = busy_count_next + 6'(busy_next[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= 32'd0;
                tag_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= 6'd0;
        end else if (rdy_in) begin
            if (commit_rd != 5'd0) begin
                val_q[commit_rd] <= commit_val;
            end
            if (rename_en) begin
                tag_q[issue_rd] <= issue_rob_id;
            end
            busy_q       <= busy_next;
            busy_count_q <= busy_count_next;
        end
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed testbench for reg_file_rename: rename, commit bypass, stale commits,
// clear, rdy_in stall and asynchronous reset, all against hand-computed values.
module tb_reg_file_rename;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        issue_req;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_id;
    logic [31:0] rs1_val;
    logic        rs1_busy;
    logic [3:0]  rs1_rob_id;
    logic [31:0] rs2_val;
    logic        rs2_busy;
    logic [3:0]  rs2_rob_id;
    logic [5:0]  busy_count;

    int tests_run    = 0;
    int tests_failed = 0;

    reg_file_rename #(.ROB_INDEX_BIT(4), .REG_NUM(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_in     (clear_in),
        .issue_req    (issue_req),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_rob_id (issue_rob_id),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .commit_rob_id(commit_rob_id),
        .rs1_val      (rs1_val),
        .rs1_busy     (rs1_busy),
        .rs1_rob_id   (rs1_rob_id),
        .rs2_val      (rs2_val),
        .rs2_busy     (rs2_busy),
        .rs2_rob_id   (rs2_rob_id),
        .busy_count   (busy_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle's issue/commit/read inputs and lets the combinational path settle.
    task automatic applyStimulus(input logic req, input logic [4:0] rd, input logic [3:0] rob,
                                 input logic [4:0] c_rd, input logic [31:0] c_val,
                                 input logic [3:0] c_rob, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
        issue_req     = req;
        issue_rd      = rd;
        issue_rob_id  = rob;
        commit_rd     = c_rd;
        commit_val    = c_val;
        commit_rob_id = c_rob;
        issue_rs1     = rs1;
        issue_rs2     = rs2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        clear_in = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("reset_rs1_val", rs1_val, 0);
        checkOutput("reset_rs1_busy", 32'(rs1_busy), 0);
        checkOutput("reset_rs1_rob", 32'(rs1_rob_id), 0);
        checkOutput("reset_count", 32'(busy_count), 0);
        #12;
        rst_in = 1'b1;

        // x0 is never renamed or written
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0);
        tick();
        checkOutput("x0_issue_count", 32'(busy_count), 0);
        applyStimulus(0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_val", rs1_val, 0);
        checkOutput("x0_busy", 32'(rs1_busy), 0);
        checkOutput("x0_count", 32'(busy_count), 0);

        // Rename then matching commit with bypass
        applyStimulus(1, 5, 2, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
        checkOutput("ren_busy", 32'(rs1_busy), 1);
        checkOutput("ren_rob", 32'(rs1_rob_id), 2);
        checkOutput("ren_count", 32'(busy_count), 1);
        applyStimulus(0, 0, 0, 5, 32'h1234, 2, 5, 5);
        checkOutput("byp_rs1_busy", 32'(rs1_busy), 0);
        checkOutput("byp_rs1_val", rs1_val, 32'h1234);
        checkOutput("byp_rs2_busy", 32'(rs2_busy), 0);
        checkOutput("byp_rs2_val", rs2_val, 32'h1234);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("cmt_count", 32'(busy_count), 0);
        checkOutput("cmt_val", rs1_val, 32'h1234);
        checkOutput("cmt_busy", 32'(rs1_busy), 0);

        // Stale commit leaves the younger producer in place
        applyStimulus(1, 7, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 7, 4, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 7, 9, 1, 7, 0);
        checkOutput("stale_byp_busy", 32'(rs1_busy), 1);
        checkOutput("stale_byp_rob", 32'(rs1_rob_id), 4);
        checkOutput("stale_byp_val", rs1_val, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 7);
        checkOutput("stale_val", rs2_val, 9);
        checkOutput("stale_busy", 32'(rs2_busy), 1);
        checkOutput("stale_rob", 32'(rs2_rob_id), 4);
        checkOutput("stale_count", 32'(busy_count), 1);

        // Same-cycle release and rename of register 3
        applyStimulus(1, 3, 6, 0, 0, 0, 0, 0);
        tick();
        checkOutput("r3_count", 32'(busy_count), 2);
        applyStimulus(1, 3, 8, 3, 32'hAA, 6, 3, 0);
        checkOutput("rr_byp_val", rs1_val, 32'hAA);
        checkOutput("rr_byp_busy", 32'(rs1_busy), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
        checkOutput("rr_busy", 32'(rs1_busy), 1);
        checkOutput("rr_rob", 32'(rs1_rob_id), 8);
        checkOutput("rr_val", rs1_val, 32'hAA);
        checkOutput("rr_count", 32'(busy_count), 2);

        // Clear with concurrent issue and commit
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 2, 2, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 9, 3, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pre_clr_count", 32'(busy_count), 5);
        clear_in = 1'b1;
        applyStimulus(1, 10, 5, 2, 5, 0, 0, 0);
        tick();
        clear_in = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 2, 10);
        checkOutput("clr_count", 32'(busy_count), 0);
        checkOutput("clr_r2_val", rs1_val, 5);
        checkOutput("clr_r2_busy", 32'(rs1_busy), 0);
        checkOutput("clr_r10_busy", 32'(rs2_busy), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 7);
        checkOutput("clr_r9_busy", 32'(rs1_busy), 0);
        checkOutput("clr_r7_val", rs2_val, 9);

        // rdy_in low holds all state
        rdy_in = 1'b0;
        applyStimulus(1, 4, 1, 6, 32'h77, 0, 4, 6);
        tick();
        checkOutput("stall_count", 32'(busy_count), 0);
        checkOutput("stall_r4_busy", 32'(rs1_busy), 0);
        checkOutput("stall_r6_val", rs2_val, 0);
        rdy_in = 1'b1;
        applyStimulus(1, 4, 1, 0, 0, 0, 4, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 4, 7);
        checkOutput("resume_busy", 32'(rs1_busy), 1);
        checkOutput("resume_rob", 32'(rs1_rob_id), 1);
        checkOutput("resume_count", 32'(busy_count), 1);

        // Asynchronous reset mid-operation, no clock edge needed
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("areset_count", 32'(busy_count), 0);
        checkOutput("areset_busy", 32'(rs1_busy), 0);
        checkOutput("areset_val", rs2_val, 0);
        rst_in = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register ROB dependency tags. It sits between the instruction unit (issue/rename side) and the reorder buffer's commit port (rd/value/rob-id).
- At issue it supplies each source operand as either a ready value or the ROB index that will produce it, and records the new producer tag for rd.
- At commit it writes the value and releases the tag only if the committing entry is still the latest producer.
- On misprediction clear it drops all tags and keeps the values.

Parameters:
- ROB_INDEX_BIT, 4, width of a ROB index.
- REG_NUM, 32, number of architectural registers (x0 hardwired to zero).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; when low, state holds and outputs remain combinationally valid.
- clear_in  input  1  misprediction flush from the ROB.
- issue_req  input  1  instruction unit is issuing this cycle.
- issue_rs1  input  5  source register 1 index.
- issue_rs2  input  5  source register 2 index.
- issue_rd  input  5  destination register index (0 = none).
- issue_rob_id  input  ROB_INDEX_BIT  ROB tail index allocated to the issuing instruction.
- commit_rd  input  5  committing destination (0 = no write).
- commit_val  input  32  committed value.
- commit_rob_id  input  ROB_INDEX_BIT  ROB index of the committing entry.
- rs1_val  output  32  value of rs1 (valid when rs1_busy = 0).
- rs1_busy  output  1  rs1 waits on a ROB entry.
- rs1_rob_id  output  ROB_INDEX_BIT  producer tag for rs1.
- rs2_val, rs2_busy, rs2_rob_id  output  32/1/ROB_INDEX_BIT  same as the rs1 outputs, for rs2.
- busy_count  output  6  number of registers currently holding a tag.

Behaviour:
State:
- val[0..31] is 32 bits wide.
- busy[0..31] is 1 bit.
- tag[0..31] is ROB_INDEX_BIT bits.

Reset (rst_in = 0, asynchronous):
- All val, busy and tag entries are cleared to 0, and busy_count is 0.
- Consequently all read outputs read 0, with busy = 0 and rob_id = 0.

Read path (combinational):
- The read path always reflects state before this edge's updates. This cycle's rename is not visible, so an instruction reading its own rd sees the old producer.
- Commit bypass: if commit_rd != 0, commit_rd == rsN, busy[rsN] = 1 and tag[rsN] == commit_rob_id, then rsN_busy = 0 and rsN_val = commit_val.
- Otherwise rsN_val = val[rsN], rsN_busy = busy[rsN] and rsN_rob_id = tag[rsN].
- rsN = 0 always gives val 0 and busy 0.

Sequential update (rising edge, rdy_in = 1), evaluated in parallel:
- Commit: if commit_rd != 0, then val[commit_rd] <= commit_val.
  - If busy[commit_rd] and tag[commit_rd] == commit_rob_id, then busy <= 0.
  - A tag mismatch means a younger producer exists, so busy stays 1.
- Rename: if issue_req, issue_rd != 0 and clear_in = 0, then busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_id.
  - Rename overrides a same-cycle commit release of the same register; the commit value write still occurs.
- Clear: if clear_in = 1, all busy <= 0 and tags are don't-care.
  - A same-cycle commit value write is still performed.
  - The issue request is ignored.
- busy_count <= popcount of the next busy vector. Its range is 0..31 (x0 is never busy).
- x0: writes are discarded and busy[0] stays 0.

Other rules:
- rdy_in = 0: no state change. The commit and issue inputs are ignored that cycle; the ROB holds its outputs, so nothing is lost.
- Reset mid-operation: takes effect immediately, and pending tags are lost.
- No handshake back-pressure: the register file always accepts one issue and one commit per cycle.
- Latency: a rename is visible on the next cycle's read; a commit is visible the same cycle through the bypass and in state from the next cycle.

Test Plan:
- Reset/x0: deassert reset, then issue rd = 0 with rob 3, then commit rd = 0 with val 0xFFFF_FFFF -> rs1 = 0 reads val 0, busy 0; busy_count stays 0.
- Rename then commit: issue rd = 5 with rob 2; next cycle read rs1 = 5 -> busy 1, rob_id 2. Commit rd = 5, rob 2, val 0x1234 -> same-cycle read gives busy 0, val 0x1234; busy_count returns from 1 to 0.
- Stale commit: issue rd = 7 with rob 1, then issue rd = 7 with rob 4, then commit rd = 7, rob 1, val 9 -> val[7] = 9, busy stays 1 with tag 4; the bypass does not fire.
- Simultaneous rename and release: with tag[3] = 6, commit rd = 3, rob 6, val 0xAA in the same cycle as issue rd = 3, rob 8, rs1 = 3 -> rs1 reads bypassed 0xAA ready. Next cycle busy[3] = 1, tag 8, val 0xAA.
- Clear: registers 1, 2 and 9 are busy; assert clear_in together with issue rd = 10 and commit rd = 2, val 5 -> next cycle all busy 0, busy_count 0, val[2] = 5, and reg 10 is not busy.
- rdy_in low: hold rdy_in = 0 while driving issue rd = 4, rob 1 -> no state change; reassert rdy_in and the same issue takes effect.
